// File: rtl/qspi_pkg.sv
// Shared encodings for the quad/single-lane serial sequencer: op codes, beat
// counts and the sequencer state type.
package qspi_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam logic [4:0] BEATS_WR     = 5'd16;
  localparam logic [4:0] BEATS_RD     = 5'd10;
  localparam logic [4:0] RD_CMD_BEATS = 5'd2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  function automatic logic [4:0] last_beat(input logic op);
    return (op == OP_READ) ? BEATS_RD : BEATS_WR;
  endfunction

endpackage

// File: rtl/qspi_tick_cnt.sv
// Loadable 8-bit down-counter that times every phase of the sequencer; it
// parks at zero until reloaded.
module qspi_tick_cnt (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/qspi_seq_ctrl.sv
// Transaction sequencer for the serial mux datapath: generates cs_n, sclk,
// beat index, lane mode and the drive/sample strobes. All outputs registered.
module qspi_seq_ctrl
  import qspi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       req_i,
  input  logic       op_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] idx_o,
  output logic       mode_o,
  output logic       drive_o,
  output logic       sample_o,
  output logic       sclk_o,
  output logic       cs_n_o
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  state_t     state;
  state_t     state_nxt;
  logic       op_q;
  logic [4:0] last;
  logic       active;
  logic       accept;
  logic       tick_zero;
  logic       tick_load;
  logic [7:0] tick_val;

  logic       ack_d;
  logic       busy_d;
  logic       done_d;
  logic [4:0] idx_d;
  logic       mode_d;
  logic       drive_d;
  logic       sample_d;
  logic       sclk_d;
  logic       cs_n_d;

  assign last   = last_beat(op_q);
  assign active = state inside {SETUP, LOW, HIGH, HOLD};
  assign accept = (state == IDLE) && req_i;

  // Every state change restarts the shared timer for the phase being entered.
  assign tick_load = (state_nxt != state);
  assign tick_val  = (state_nxt == GAP) ? GAP_LOAD : DIV_LOAD;

  qspi_tick_cnt u_tick (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load      (tick_load),
    .load_val  (tick_val),
    .zero      (tick_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      op_q     <= OP_WRITE;
      ack_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      idx_o    <= '0;
      mode_o   <= 1'b0;
      drive_o  <= 1'b0;
      sample_o <= 1'b0;
      sclk_o   <= 1'b0;
      cs_n_o   <= 1'b1;
    end else begin
      state    <= state_nxt;
      if (accept) op_q <= op_i;
      ack_o    <= ack_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      idx_o    <= idx_d;
      mode_o   <= mode_d;
      drive_o  <= drive_d;
      sample_o <= sample_d;
      sclk_o   <= sclk_d;
      cs_n_o   <= cs_n_d;
    end
  end

  // Abort takes priority over any timer expiry, including the HOLD completion.
  always_comb begin
    state_nxt = state;
    if (active && abort_i) begin
      state_nxt = GAP;
    end else begin
      unique case (state)
        IDLE:  if (req_i) state_nxt = SETUP;
        SETUP: if (tick_zero) state_nxt = LOW;
        LOW:   if (tick_zero) state_nxt = HIGH;
        HIGH:  if (tick_zero) state_nxt = (idx_o == last) ? HOLD : LOW;
        HOLD:  if (tick_zero) state_nxt = GAP;
        GAP:   if (tick_zero) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next output values derived from the transition; idx only moves on LOW entry.
  always_comb begin
    ack_d    = accept;
    busy_d   = (state_nxt != IDLE);
    done_d   = (state == HOLD) && tick_zero && !abort_i;
    cs_n_d   = !(state_nxt inside {SETUP, LOW, HIGH, HOLD});
    sclk_d   = (state_nxt == HIGH);
    mode_d   = mode_o;
    if (accept) mode_d = (op_i == OP_READ) ? 1'b1 : mode_i;

    idx_d = idx_o;
    if (state_nxt == GAP || state_nxt == IDLE) begin
      idx_d = '0;
    end else if (state == SETUP && state_nxt == LOW) begin
      idx_d = 5'd1;
    end else if (state == HIGH && state_nxt == LOW) begin
      idx_d = idx_o + 5'd1;
    end

    drive_d  = (state_nxt inside {LOW, HIGH}) &&
               (op_q == OP_WRITE || idx_d <= RD_CMD_BEATS);
    sample_d = (state == LOW) && (state_nxt == HIGH) &&
               (op_q == OP_READ) && (idx_o >= 5'd3);
  end

endmodule

// File: tb/tb_qspi_seq_ctrl.sv
// Directed self-checking bench for qspi_seq_ctrl: one DUT at CLK_DIV=2 and one
// at CLK_DIV=1, both with CS_GAP=4.
module tb_qspi_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n, req, op, mode, abort, sel;
  int   total, bad;

  always #5 clk = ~clk;

  logic       ack0, busy0, done0, mode0, drive0, sample0, sclk0, cs_n0;
  logic       ack1, busy1, done1, mode1, drive1, sample1, sclk1, cs_n1;
  logic [4:0] idx0, idx1;

  qspi_seq_ctrl #(.CLK_DIV(2), .CS_GAP(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req & ~sel), .op_i(op), .mode_i(mode),
    .abort_i(abort & ~sel), .ack_o(ack0), .busy_o(busy0), .done_o(done0), .idx_o(idx0),
    .mode_o(mode0), .drive_o(drive0), .sample_o(sample0), .sclk_o(sclk0), .cs_n_o(cs_n0));

  qspi_seq_ctrl #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req & sel), .op_i(op), .mode_i(mode),
    .abort_i(abort & sel), .ack_o(ack1), .busy_o(busy1), .done_o(done1), .idx_o(idx1),
    .mode_o(mode1), .drive_o(drive1), .sample_o(sample1), .sclk_o(sclk1), .cs_n_o(cs_n1));

  logic       m_ack, m_busy, m_done, m_mode, m_drive, m_sample, m_sclk, m_cs_n;
  logic [4:0] m_idx;
  assign m_ack    = sel ? ack1    : ack0;
  assign m_busy   = sel ? busy1   : busy0;
  assign m_done   = sel ? done1   : done0;
  assign m_mode   = sel ? mode1   : mode0;
  assign m_drive  = sel ? drive1  : drive0;
  assign m_sample = sel ? sample1 : sample0;
  assign m_sclk   = sel ? sclk1   : sclk0;
  assign m_cs_n   = sel ? cs_n1   : cs_n0;
  assign m_idx    = sel ? idx1    : idx0;

  int         n_ack, n_done, cs_low, n_rise, sclk_hi, n_samp, samp_good;
  int         drv_cnt, drv_bad, idx_max, idx_bad, gap, timeout;
  logic       mode_at_ack, ab_cs, ab_sclk, ab_drive, ab_done;
  logic [4:0] ab_idx;

  // Runs one transaction and gathers what was observed on the selected DUT.
  task automatic run_txn(input logic t_op, input logic t_mode, input int abort_at,
                         input int drv_hi_max);
    int cyc;
    bit started, seen_rise, in_ab, aborted;
    logic prev_sclk, prev_cs;
    logic [4:0] prev_idx;
    n_ack = 0; n_done = 0; cs_low = 0; n_rise = 0; sclk_hi = 0; n_samp = 0;
    samp_good = 0; drv_cnt = 0; drv_bad = 0; idx_max = 0; idx_bad = 0; gap = 0;
    timeout = 0; mode_at_ack = 1'bx; ab_cs = 1'bx; ab_sclk = 1'bx; ab_drive = 1'bx;
    ab_done = 1'bx; ab_idx = 'x;
    cyc = 0; started = 0; seen_rise = 0; in_ab = 0; aborted = 0;
    prev_sclk = 0; prev_cs = 1; prev_idx = 0;
    @(negedge clk);
    op = t_op; mode = t_mode; req = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (in_ab) begin
        ab_cs = m_cs_n; ab_sclk = m_sclk; ab_drive = m_drive; ab_done = m_done; ab_idx = m_idx;
        abort = 1'b0; in_ab = 0;
      end
      if (m_ack) begin n_ack++; mode_at_ack = m_mode; req = 1'b0; started = 1; end
      if (m_done) n_done++;
      if (!m_cs_n) cs_low++;
      if (m_sclk && !prev_sclk) n_rise++;
      if (m_sclk) sclk_hi++;
      if (m_sample) begin
        n_samp++;
        if (m_sclk && m_idx >= 5'd3 && m_idx <= 5'd10) samp_good++;
      end
      if (m_drive) begin
        drv_cnt++;
        if (m_idx == 5'd0 || int'(m_idx) > drv_hi_max) drv_bad++;
      end
      if (m_idx != prev_idx && ((m_idx != prev_idx + 5'd1 && m_idx != 5'd0) || m_sclk)) idx_bad++;
      if (int'(m_idx) > idx_max) idx_max = int'(m_idx);
      if (m_cs_n && !prev_cs) seen_rise = 1;
      if (seen_rise && m_busy) gap++;
      if (abort_at != 0 && !aborted && int'(m_idx) == abort_at && m_sclk) begin
        abort = 1'b1; in_ab = 1; aborted = 1;
      end
      prev_sclk = m_sclk; prev_cs = m_cs_n; prev_idx = m_idx;
      if (started && !m_busy) break;
      if (cyc > 400) begin timeout = 1; req = 1'b0; abort = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 0; op = 0; mode = 0; abort = 0; sel = 0;
    repeat (3) @(negedge clk);
    total++; if (m_ack !== 1'b0) begin $display("[TB] FAIL rst_ack: got %b want 0", m_ack); bad++; end
    total++; if (m_busy !== 1'b0) begin $display("[TB] FAIL rst_busy: got %b want 0", m_busy); bad++; end
    total++; if (m_done !== 1'b0) begin $display("[TB] FAIL rst_done: got %b want 0", m_done); bad++; end
    total++; if (m_idx !== 5'd0) begin $display("[TB] FAIL rst_idx: got %0d want 0", m_idx); bad++; end
    total++; if (m_mode !== 1'b0) begin $display("[TB] FAIL rst_mode: got %b want 0", m_mode); bad++; end
    total++; if (m_drive !== 1'b0) begin $display("[TB] FAIL rst_drive: got %b want 0", m_drive); bad++; end
    total++; if (m_sample !== 1'b0) begin $display("[TB] FAIL rst_sample: got %b want 0", m_sample); bad++; end
    total++; if (m_sclk !== 1'b0) begin $display("[TB] FAIL rst_sclk: got %b want 0", m_sclk); bad++; end
    total++; if (m_cs_n !== 1'b1) begin $display("[TB] FAIL rst_cs_n: got %b want 1", m_cs_n); bad++; end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_quad();
    run_txn(1'b0, 1'b1, 0, 16);
    total++; if (timeout != 0) begin $display("[TB] FAIL wr_timeout: got %0d want 0", timeout); bad++; end
    total++; if (n_ack != 1) begin $display("[TB] FAIL wr_ack: got %0d want 1", n_ack); bad++; end
    total++; if (n_rise != 16) begin $display("[TB] FAIL wr_rises: got %0d want 16", n_rise); bad++; end
    total++; if (idx_max != 16) begin $display("[TB] FAIL wr_idx_max: got %0d want 16", idx_max); bad++; end
    total++; if (idx_bad != 0) begin $display("[TB] FAIL wr_idx_seq: got %0d want 0", idx_bad); bad++; end
    total++; if (mode_at_ack !== 1'b1) begin $display("[TB] FAIL wr_mode: got %b want 1", mode_at_ack); bad++; end
    total++; if (drv_cnt != 64 || drv_bad != 0) begin $display("[TB] FAIL wr_drive: got %0d/%0d want 64/0", drv_cnt, drv_bad); bad++; end
    total++; if (cs_low != 68) begin $display("[TB] FAIL wr_cs_low: got %0d want 68", cs_low); bad++; end
    total++; if (n_done != 1) begin $display("[TB] FAIL wr_done: got %0d want 1", n_done); bad++; end
    total++; if (gap != 4) begin $display("[TB] FAIL wr_busy_gap: got %0d want 4", gap); bad++; end
    total++; if (n_samp != 0) begin $display("[TB] FAIL wr_sample: got %0d want 0", n_samp); bad++; end
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b0, 0, 2);
    total++; if (timeout != 0) begin $display("[TB] FAIL rd_timeout: got %0d want 0", timeout); bad++; end
    total++; if (mode_at_ack !== 1'b1) begin $display("[TB] FAIL rd_mode: got %b want 1", mode_at_ack); bad++; end
    total++; if (n_rise != 10) begin $display("[TB] FAIL rd_rises: got %0d want 10", n_rise); bad++; end
    total++; if (idx_max != 10 || idx_bad != 0) begin $display("[TB] FAIL rd_idx: got max %0d bad %0d want 10/0", idx_max, idx_bad); bad++; end
    total++; if (drv_cnt != 8 || drv_bad != 0) begin $display("[TB] FAIL rd_drive: got %0d/%0d want 8/0", drv_cnt, drv_bad); bad++; end
    total++; if (n_samp != 8 || samp_good != 8) begin $display("[TB] FAIL rd_sample: got %0d/%0d want 8/8", n_samp, samp_good); bad++; end
    total++; if (cs_low != 44) begin $display("[TB] FAIL rd_cs_low: got %0d want 44", cs_low); bad++; end
    total++; if (n_done != 1) begin $display("[TB] FAIL rd_done: got %0d want 1", n_done); bad++; end
  endtask

  task automatic test_clk_div1();
    sel = 1'b1;
    run_txn(1'b0, 1'b0, 0, 16);
    total++; if (timeout != 0) begin $display("[TB] FAIL div1_timeout: got %0d want 0", timeout); bad++; end
    total++; if (n_rise != 16 || sclk_hi != 16) begin $display("[TB] FAIL div1_sclk: got %0d/%0d want 16/16", n_rise, sclk_hi); bad++; end
    total++; if (drv_cnt != 32) begin $display("[TB] FAIL div1_drive: got %0d want 32", drv_cnt); bad++; end
    total++; if (cs_low != 34) begin $display("[TB] FAIL div1_cs_low: got %0d want 34", cs_low); bad++; end
    total++; if (mode_at_ack !== 1'b0) begin $display("[TB] FAIL div1_mode: got %b want 0", mode_at_ack); bad++; end
    total++; if (idx_max != 16 || idx_bad != 0) begin $display("[TB] FAIL div1_idx: got max %0d bad %0d want 16/0", idx_max, idx_bad); bad++; end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    run_txn(1'b0, 1'b1, 5, 16);
    total++; if (timeout != 0) begin $display("[TB] FAIL ab_timeout: got %0d want 0", timeout); bad++; end
    total++; if (ab_cs !== 1'b1) begin $display("[TB] FAIL ab_cs_n: got %b want 1", ab_cs); bad++; end
    total++; if (ab_idx !== 5'd0) begin $display("[TB] FAIL ab_idx: got %0d want 0", ab_idx); bad++; end
    total++; if (ab_drive !== 1'b0 || ab_sclk !== 1'b0) begin $display("[TB] FAIL ab_drive_sclk: got %b%b want 00", ab_drive, ab_sclk); bad++; end
    total++; if (n_done != 0) begin $display("[TB] FAIL ab_done: got %0d want 0", n_done); bad++; end
    total++; if (gap != 4) begin $display("[TB] FAIL ab_busy_gap: got %0d want 4", gap); bad++; end
    total++; if (idx_max != 5) begin $display("[TB] FAIL ab_idx_max: got %0d want 5", idx_max); bad++; end
  endtask

  task automatic test_back_to_back();
    int acks, falls, hi_run, late_acks, cyc;
    logic prev_cs;
    acks = 0; falls = 0; hi_run = 0; late_acks = 0; cyc = 0; prev_cs = 1'b1;
    @(negedge clk);
    op = 1'b0; mode = 1'b1; req = 1'b1;
    while (falls < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m_ack) acks++;
      if (!m_cs_n && prev_cs) falls++;
      if (falls == 1 && m_cs_n) hi_run++;
      prev_cs = m_cs_n;
    end
    total++; if (falls != 2) begin $display("[TB] FAIL b2b_timeout: got %0d falls want 2", falls); bad++; end
    total++; if (acks != 2) begin $display("[TB] FAIL b2b_acks: got %0d want 2", acks); bad++; end
    total++; if (hi_run != 5) begin $display("[TB] FAIL b2b_cs_high: got %0d want 5", hi_run); bad++; end
    cyc = 0;
    while (m_busy && cyc < 300) begin
      req = (cyc < 20) ? cyc[0] : 1'b0;
      @(negedge clk);
      cyc++;
      if (m_ack) late_acks++;
    end
    req = 1'b0;
    total++; if (m_busy !== 1'b0) begin $display("[TB] FAIL b2b_drain: got busy %b want 0", m_busy); bad++; end
    total++; if (late_acks != 0) begin $display("[TB] FAIL b2b_busy_req: got %0d acks want 0", late_acks); bad++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    op = 1'b0; mode = 1'b1; req = 1'b1;
    while (!(m_idx == 5'd9) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_ack) req = 1'b0;
    end
    total++; if (m_idx !== 5'd9) begin $display("[TB] FAIL mid_reach_idx9: got %0d want 9", m_idx); bad++; end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (m_cs_n !== 1'b1 || m_sclk !== 1'b0) begin $display("[TB] FAIL mid_cs_sclk: got %b%b want 10", m_cs_n, m_sclk); bad++; end
    total++; if (m_idx !== 5'd0) begin $display("[TB] FAIL mid_idx: got %0d want 0", m_idx); bad++; end
    total++; if (m_busy !== 1'b0 || m_drive !== 1'b0) begin $display("[TB] FAIL mid_busy_drive: got %b%b want 00", m_busy, m_drive); bad++; end
    total++; if (m_mode !== 1'b0 || m_ack !== 1'b0 || m_done !== 1'b0 || m_sample !== 1'b0) begin
      $display("[TB] FAIL mid_misc: got mode%b ack%b done%b samp%b want 0000", m_mode, m_ack, m_done, m_sample); bad++; end
    @(negedge clk);
    run_txn(1'b0, 1'b1, 0, 16);
    total++; if (timeout != 0) begin $display("[TB] FAIL mid_after_timeout: got %0d want 0", timeout); bad++; end
    total++; if (cs_low != 68) begin $display("[TB] FAIL mid_after_cs_low: got %0d want 68", cs_low); bad++; end
    total++; if (n_done != 1 || idx_max != 16) begin $display("[TB] FAIL mid_after_done: got %0d/%0d want 1/16", n_done, idx_max); bad++; end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_write_quad();
    test_read();
    test_clk_div1();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
